// File: rtl/sram_1w1r_init_bypass.sv
// rtl/sram_1w1r_init_bypass.sv - 1W1R macro front-end: init sweep, read-during-write bypass, read data hold
module sram_1w1r_init_bypass #(
    parameter int                 DEPTH      = 40,
    parameter int                 ADDR_W     = 6,
    parameter int                 DATA_W     = 72,
    parameter int                 MASK_W     = 1,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                init_start,
    output logic                init_done,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic [DATA_W-1:0]   W0_data,
    input  logic                W0_en,
    input  logic [MASK_W-1:0]   W0_mask,
    input  logic [ADDR_W-1:0]   R0_addr,
    input  logic                R0_en,
    output logic [DATA_W-1:0]   R0_data,
    output logic [ADDR_W-1:0]   m_W0_addr,
    output logic [DATA_W-1:0]   m_W0_data,
    output logic                m_W0_en,
    output logic [MASK_W-1:0]   m_W0_mask,
    output logic [ADDR_W-1:0]   m_R0_addr,
    output logic                m_R0_en,
    input  logic [DATA_W-1:0]   m_R0_data
);
    localparam int                LW       = DATA_W / MASK_W;
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic               rd_v_q;
    logic               oob_q;
    logic               byp_q;
    logic [DATA_W-1:0]  bdata_q;
    logic [MASK_W-1:0]  bmask_q;
    logic [DATA_W-1:0]  hold_q;
    logic [DATA_W-1:0]  merged;
    logic               w_in_range;
    logic               r_in_range;

    assign w_in_range = {1'b0, W0_addr} < DEPTH_A;
    assign r_in_range = {1'b0, R0_addr} < DEPTH_A;
    assign init_done  = (state == ST_RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else if (state == ST_INIT) begin
            // ptr parks at the last entry; a restart always reloads it to zero
            if (ptr == PTR_LAST) begin
                state <= ST_RUN;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end else if (init_start) begin
            state <= ST_INIT;
            ptr   <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_v_q  <= 1'b0;
            oob_q   <= 1'b0;
            byp_q   <= 1'b0;
            bdata_q <= '0;
            bmask_q <= '0;
            hold_q  <= '0;
        end else begin
            hold_q <= R0_data;
            if (state == ST_RUN) begin
                rd_v_q  <= R0_en;
                oob_q   <= ~r_in_range;
                byp_q   <= R0_en & W0_en & (W0_addr == R0_addr) & w_in_range;
                bdata_q <= W0_data;
                bmask_q <= W0_mask;
            end else begin
                rd_v_q <= 1'b0;
                oob_q  <= 1'b0;
                byp_q  <= 1'b0;
            end
        end
    end

    // Macro ports are combinational so traffic reaches the macro in the same cycle
    always_comb begin
        m_W0_en   = 1'b0;
        m_W0_addr = '0;
        m_W0_data = '0;
        m_W0_mask = '0;
        m_R0_en   = 1'b0;
        m_R0_addr = '0;
        if (reset_n) begin
            if (state == ST_INIT) begin
                m_W0_en   = 1'b1;
                m_W0_addr = ADDR_W'(ptr);
                m_W0_data = INIT_VALUE;
                m_W0_mask = '1;
            end else begin
                m_W0_en   = W0_en & w_in_range;
                m_W0_addr = W0_addr;
                m_W0_data = W0_data;
                m_W0_mask = W0_mask;
                m_R0_en   = R0_en & r_in_range;
                m_R0_addr = R0_addr;
            end
        end
    end

    // Macro returns pre-write data on a same-cycle collision; patch written lanes
    always_comb begin
        merged = m_R0_data;
        for (int i = 0; i < MASK_W; i++) begin
            if (byp_q && bmask_q[i]) begin
                merged[i*LW +: LW] = bdata_q[i*LW +: LW];
            end
        end
        if (oob_q) begin
            merged = INIT_VALUE;
        end
    end

    assign R0_data = rd_v_q ? merged : hold_q;

endmodule

// File: tb/tb_sram_1w1r_init_bypass.sv
// tb/tb_sram_1w1r_init_bypass.sv - scoreboard bench for sram_1w1r_init_bypass with a behavioural 1W1R macro
module tb_sram_1w1r_init_bypass;
    localparam int DEPTH  = 40;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int MASK_W = 2;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               init_start;
    logic               init_done;
    logic [ADDR_W-1:0]  W0_addr;
    logic [DATA_W-1:0]  W0_data;
    logic               W0_en;
    logic [MASK_W-1:0]  W0_mask;
    logic [ADDR_W-1:0]  R0_addr;
    logic               R0_en;
    logic [DATA_W-1:0]  R0_data;
    logic [ADDR_W-1:0]  m_W0_addr;
    logic [DATA_W-1:0]  m_W0_data;
    logic               m_W0_en;
    logic [MASK_W-1:0]  m_W0_mask;
    logic [ADDR_W-1:0]  m_R0_addr;
    logic               m_R0_en;
    logic [DATA_W-1:0]  m_R0_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int                 at;
        logic [DATA_W-1:0]  val;
        string              name;
    } exp_t;
    exp_t exp_q[$];

    sram_1w1r_init_bypass #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_VALUE('0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .init_start(init_start), .init_done(init_done),
        .W0_addr(W0_addr), .W0_data(W0_data), .W0_en(W0_en), .W0_mask(W0_mask),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
        .m_W0_addr(m_W0_addr), .m_W0_data(m_W0_data), .m_W0_en(m_W0_en), .m_W0_mask(m_W0_mask),
        .m_R0_addr(m_R0_addr), .m_R0_en(m_R0_en), .m_R0_data(m_R0_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Macro model: pre-filled with a marker so a missing sweep is visible
    logic [DATA_W-1:0] mem [0:63] = '{default: 16'hDEAD};
    always @(posedge clock) begin
        if (m_W0_en) begin
            for (int l = 0; l < MASK_W; l++) begin
                if (m_W0_mask[l]) mem[m_W0_addr][l*8 +: 8] <= m_W0_data[l*8 +: 8];
            end
        end
        if (m_R0_en) m_R0_data <= mem[m_R0_addr];
    end

    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (e.at != cyc) begin
                bad++;
                $display("FAIL %s missed check slot at=%0d now=%0d", e.name, e.at, cyc);
            end else if (R0_data !== e.val) begin
                bad++;
                $display("FAIL %s R0_data=%h expected=%h (cyc %0d)", e.name, R0_data, e.val, cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        init_start = 1'b0;
        W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
        R0_en = 1'b0; R0_addr = '0;
    endtask

    task automatic push_exp(input string name, input logic [DATA_W-1:0] v, input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{at: first + k, val: v, name: name});
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        idle();
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m;
        #1;
        chk("wr_fwd", {31'd0, m_W0_en}, 32'd1);
        cycle();
        idle();
    endtask

    task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic w_en,
                      input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] wm,
                      input logic [DATA_W-1:0] exp, input int hold);
        idle();
        R0_en = 1'b1; R0_addr = a;
        W0_en = w_en; W0_addr = a; W0_data = wd; W0_mask = wm;
        push_exp(name, exp, cyc + 1, 1 + hold);
        cycle();
        idle();
        repeat (hold) cycle();
    endtask

    // Drives blocked traffic each cycle and checks the macro write port walks the sweep
    task automatic sweep(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            W0_en = 1'b1; W0_addr = 6'd5; W0_data = 16'h0077; W0_mask = 2'b11;
            R0_en = 1'b1; R0_addr = 6'd5;
            init_start = (i == 10);
            #1;
            chk($sformatf("sweep_%0d", i),
                {5'd0, m_W0_en, m_W0_addr, m_W0_data, m_W0_mask, init_done, m_R0_en},
                {5'd0, 1'b1, 6'(i), 16'h0000, 2'b11, 1'b0, 1'b0});
            cycle();
        end
        idle();
        if (full) begin
            #1;
            chk("init_done_after_sweep", {31'd0, init_done}, 32'd1);
            chk("idle_no_write", {31'd0, m_W0_en}, 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (3) cycle();
        chk("reset_outputs",
            {m_W0_en, m_R0_en, init_done, m_W0_addr, m_R0_addr, m_W0_mask, R0_data},
            32'd0);
        chk("reset_m_data", {16'd0, m_W0_data}, 32'd0);

        reset_n = 1'b1;
        push_exp("init_r0_zero", 16'h0000, cyc, DEPTH);
        sweep(DEPTH, 1'b1);

        wr(6'd7, 16'h00A5, 2'b11);
        rd("rd_after_wr", 6'd7, 1'b0, '0, '0, 16'h00A5, 5);

        wr(6'd3, 16'hFFFF, 2'b11);
        rd("bypass_hi_lane", 6'd3, 1'b1, 16'h1234, 2'b10, 16'h12FF, 0);
        rd("bypass_lo_lane", 6'd3, 1'b1, 16'h0000, 2'b01, 16'h1200, 0);
        rd("rd_merged_store", 6'd3, 1'b0, '0, '0, 16'h1200, 0);
        rd("bypass_full", 6'd10, 1'b1, 16'hBEEF, 2'b11, 16'hBEEF, 0);

        W0_en = 1'b1; W0_addr = 6'd45; W0_data = 16'h9999; W0_mask = 2'b11;
        #1;
        chk("oob_wr_45_dropped", {31'd0, m_W0_en}, 32'd0);
        W0_addr = 6'd40;
        #1;
        chk("oob_wr_40_dropped", {31'd0, m_W0_en}, 32'd0);
        idle();
        wr(6'd39, 16'h4242, 2'b11);
        rd("rd_last_entry", 6'd39, 1'b0, '0, '0, 16'h4242, 0);
        R0_en = 1'b1; R0_addr = 6'd45;
        #1;
        chk("oob_rd_blocked", {31'd0, m_R0_en}, 32'd0);
        rd("rd_oob", 6'd45, 1'b1, 16'h9999, 2'b11, 16'h0000, 2);

        wr(6'd5, 16'h0077, 2'b11);
        idle();
        R0_en = 1'b1; R0_addr = 6'd7; init_start = 1'b1;
        push_exp("rd_at_init_start", 16'h00A5, cyc + 1, DEPTH);
        cycle();
        sweep(DEPTH, 1'b1);
        rd("rd5_after_reinit", 6'd5, 1'b0, '0, '0, 16'h0000, 0);
        rd("rd7_after_reinit", 6'd7, 1'b0, '0, '0, 16'h0000, 0);

        wr(6'd2, 16'h3C3C, 2'b11);
        rd("rd_before_abort", 6'd2, 1'b0, '0, '0, 16'h3C3C, 0);
        init_start = 1'b1;
        push_exp("hold_partial_sweep", 16'h3C3C, cyc + 1, 20);
        cycle();
        sweep(20, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("abort_reset_outputs",
            {m_W0_en, m_R0_en, init_done, m_W0_addr, m_R0_addr, m_W0_mask, R0_data},
            32'd0);
        chk("abort_reset_m_data", {16'd0, m_W0_data}, 32'd0);
        cycle();
        cycle();
        reset_n = 1'b1;
        push_exp("restart_r0_zero", 16'h0000, cyc, DEPTH);
        sweep(DEPTH, 1'b1);
        wr(6'd2, 16'h5A5A, 2'b01);
        rd("rd_partial_mask", 6'd2, 1'b0, '0, '0, 16'h005A, 0);
        rd("rd30_swept", 6'd30, 1'b0, '0, '0, 16'h0000, 0);

        repeat (3) cycle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_1w1r_init_bypass.md
# sram_1w1r_init_bypass

Front-end for the 1W1R OpenRAM macro wrappers (branch-predictor tables, ghist, meta, ROB debug memory). It sits directly upstream of a `*_ext` 1W1R wrapper. After reset, or on request, it sweeps the macro to a known value. At run time it forwards write/read traffic, resolves same-address read-during-write by bypass, and holds read data stable between reads, because macro `dout1` is only guaranteed valid in the cycle after a read.

## Interface
Parameters:
- DEPTH, 40: number of macro entries; legal addresses are 0..DEPTH-1.
- ADDR_W, 6: address width; requires 2^ADDR_W ≥ DEPTH.
- DATA_W, 72: word width.
- MASK_W, 1: write-mask lanes; DATA_W must be divisible by MASK_W; lane width LW = DATA_W/MASK_W.
- INIT_VALUE, 0: DATA_W-bit value written to every entry during init.

Ports (one clock domain; reset asynchronous, active-low):
- clock  in  1  single clock; also drives the macro's W0_clk/R0_clk.
- reset_n  in  1  async active-low reset.
- init_start  in  1  one-cycle pulse requesting re-initialisation.
- init_done  out  1  high when in RUN.
- W0_addr  in  ADDR_W  write address.
- W0_data  in  DATA_W  write data.
- W0_en  in  1  write enable.
- W0_mask  in  MASK_W  per-lane write enable; bit i covers bits [i*LW+LW-1 : i*LW].
- R0_addr  in  ADDR_W  read address.
- R0_en  in  1  read enable.
- R0_data  out  DATA_W  read data, one cycle after R0_en.
- m_W0_addr / m_W0_data / m_W0_en / m_W0_mask  out  ADDR_W / DATA_W / 1 / MASK_W  to macro wrapper write port.
- m_R0_addr / m_R0_en  out  ADDR_W / 1  to macro wrapper read port.
- m_R0_data  in  DATA_W  from macro wrapper; valid one cycle after m_R0_en.

## Operation
- State machine with states INIT and RUN. Reset enters INIT with sweep counter `ptr` = 0.
- INIT:
  - each cycle drives m_W0_en=1, m_W0_addr=ptr, m_W0_data=INIT_VALUE, m_W0_mask=all ones; ptr increments.
  - when ptr = DEPTH-1 is written, go to RUN.
  - Upstream W0_en and R0_en are ignored: no write is forwarded, m_R0_en=0, and the read is not tracked.
  - init_start is ignored.
- RUN:
  - Writes pass through: m_W0_* = W0_*, and m_W0_en = W0_en & (W0_addr < DEPTH).
  - Reads pass through: m_R0_addr = R0_addr, and m_R0_en = R0_en & (R0_addr < DEPTH).
  - init_start=1 moves to INIT next cycle with ptr=0. Traffic in the init_start cycle is still forwarded.
- Read tracking registers, captured every RUN cycle:
  - rd_v_q = R0_en.
  - oob_q = R0_addr ≥ DEPTH.
  - byp_q = R0_en & W0_en & (W0_addr == R0_addr) & in-range.
  - bdata_q = W0_data.
  - bmask_q = W0_mask.
- Merge (cycle after read):
  - out-of-range read (oob_q): merged = INIT_VALUE.
  - otherwise lane i = (byp_q & bmask_q[i]) ? bdata_q lane i : m_R0_data lane i.
  - Read-during-write therefore returns new data for written lanes and old data for the rest.
- Output hold:
  - R0_data = rd_v_q ? merged : hold_q.
  - hold_q <= R0_data every cycle.
- Out-of-range writes are dropped silently.

## Timing
- Reset values:
  - state=INIT, ptr=0, init_done=0.
  - m_W0_en=0, m_R0_en=0, m_W0_addr=0, m_R0_addr=0, m_W0_data=0, m_W0_mask=0.
  - rd_v_q=0, byp_q=0, oob_q=0, hold_q=0, hence R0_data=0.
- m_* outputs are combinational from state/ptr/upstream inputs, with no added latency. While reset_n is low they are forced to their reset values.
- Init duration: exactly DEPTH cycles. The first clock edge after reset_n deasserts writes address 0. init_done rises on the edge that writes DEPTH-1, so it is high in cycle DEPTH (counting from 0 at the first edge).
- Read latency is 1 cycle: R0_en at edge t gives R0_data valid from t until edge t+1, and held afterwards until the next read completes.
- Write-then-read to the same address in consecutive cycles needs no bypass. The macro write completes at edge t and the read at t+1 sees it.
- Reset asserted mid-init or mid-run: immediate async return to reset values. Init restarts from address 0 on deassert.
- init_start in the same cycle as a read: that read still completes normally. R0_data during the following INIT holds the value from that read.
- ptr width is ceil(log2(DEPTH)) and it never wraps. The INIT→RUN transition occurs at DEPTH-1.

## Test plan
- Reset release with DEPTH=40: m_W0_en=1 for exactly 40 cycles, addresses 0..39 with data 0 and full mask. init_done=1 from cycle 40. R0_data=0 throughout.
- RUN: write 0xA5 to addr 7, read addr 7 next cycle → R0_data=0xA5 one cycle after R0_en. With R0_en low for 5 cycles, R0_data stays 0xA5.
- Same-cycle write 0x1234 and read at addr 3, with old value 0xFFFF, MASK_W=2, LW=8, mask=2'b10 → R0_data=0x12FF.
- W0_en with W0_addr=45 (≥40) → m_W0_en=0. Read addr 45 → R0_data=INIT_VALUE.
- Write 0x77 to addr 5, pulse init_start → 40-cycle sweep with init_done=0 and upstream writes blocked. Afterwards a read of addr 5 returns 0.
- Assert reset_n=0 at sweep cycle 20 → all outputs go to reset values at once. After release, the sweep restarts at addr 0 and takes a full 40 cycles.
